// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter family: op encoding and sequencer states.
// The combinational shifter decodes the same op field with these constants.
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_SLL = 3'd0;
    localparam logic [OP_W-1:0] OP_SRL = 3'd1;
    localparam logic [OP_W-1:0] OP_SRA = 3'd2;
    localparam logic [OP_W-1:0] OP_ROL = 3'd3;
    localparam logic [OP_W-1:0] OP_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic op_valid(input logic [OP_W-1:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/shift_step1.sv
// Single-position shift/rotate of a WIDTH-bit word; invalid ops yield zero.
module shift_step1
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic [OP_W-1:0]  op,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        case (op)
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            OP_SRA:  dout = {fill, din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/shifter_seq.sv
// Iterative shifter: one bit position per clock under a start/done handshake.
// Supports the SLL/SRL/SRA/ROL/ROR ops of the combinational shifter.
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shiftamt,
    input  logic [OP_W-1:0]    op,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [SHAMT_W-1:0] count;
    logic [OP_W-1:0]    op_q;
    logic               fill_q;

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (work),
        .op   (op_q),
        .fill (fill_q),
        .dout (work_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            op_q   <= OP_SLL;
            fill_q <= 1'b0;
            y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= shiftamt;
                        op_q   <= op;
                        fill_q <= data[WIDTH-1];
                        if (!op_valid(op)) begin
                            work  <= '0;
                            y     <= '0;
                            state <= DONE;
                        end else if (shiftamt == '0) begin
                            work  <= data;
                            y     <= data;
                            state <= DONE;
                        end else begin
                            work  <= data;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work  <= work_next;
                    count <= count - SHAMT_W'(1);
                    // Final shift lands on the same edge that enters DONE.
                    if (count == SHAMT_W'(1)) begin
                        y     <= work_next;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = ~ready;
    assign done  = (state == DONE);

endmodule
